// File: rtl/aes_round_sequencer_pkg.sv
// Shared AES-128 definitions: round count, state type, FSM encoding, S-box and GF(2^8) helpers.
package aes_round_sequencer_pkg;

  localparam int NR = 10;

  typedef logic [0:127] aes_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // xtime: multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] mul_by2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul_by3(input logic [7:0] b);
    return mul_by2(b) ^ b;
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Block-in / key-fetch / ciphertext-out bundle of the AES round sequencer.
interface aes_round_sequencer_if;
  import aes_round_sequencer_pkg::*;

  logic       inValid;
  logic       inReady;
  aes_state_t inBlock;
  logic [3:0] keyIdx;
  aes_state_t roundKey;
  logic       outValid;
  logic       outReady;
  aes_state_t outBlock;
  logic       busy;

  modport master (
    output inValid, inBlock, roundKey, outReady,
    input  inReady, keyIdx, outValid, outBlock, busy
  );

  modport slave (
    input  inValid, inBlock, roundKey, outReady,
    output inReady, keyIdx, outValid, outBlock, busy
  );

endinterface

// File: rtl/aes_round_sequencer_round.sv
// Combinational AES round (SubBytes, ShiftRows, MixColumns, AddRoundKey) and its column mixer.
module aes_round_sequencer_mix_column
  import aes_round_sequencer_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);
  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col;

  assign mixed = {
    mul_by2(a0) ^ mul_by3(a1) ^ a2          ^ a3,
    a0          ^ mul_by2(a1) ^ mul_by3(a2) ^ a3,
    a0          ^ a1          ^ mul_by2(a2) ^ mul_by3(a3),
    mul_by3(a0) ^ a1          ^ a2          ^ mul_by2(a3)
  };
endmodule

module aes_round_sequencer_round
  import aes_round_sequencer_pkg::*;
(
  input  aes_state_t inState,
  input  aes_state_t roundKey,
  input  logic       lastRound,
  output aes_state_t outState
);
  aes_state_t sub;
  aes_state_t shifted;
  aes_state_t mixed;

  always_comb begin
    sub = '0;
    for (int i = 0; i < 16; i++) begin
      sub[8*i +: 8] = SBOX[inState[8*i +: 8]];
    end
  end

  // Byte (r,c) sits at index r+4c; row r rotates left by r columns.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[8*(r+4*c) +: 8] = sub[8*(r+4*((c+r)%4)) +: 8];
      end
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    aes_round_sequencer_mix_column u_mix (
      .col   (shifted[32*c +: 32]),
      .mixed (mixed[32*c +: 32])
    );
  end

  assign outState = (lastRound ? shifted : mixed) ^ roundKey;
endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one round per clock over a shared round datapath, one block in flight.
module aes_round_sequencer
  import aes_round_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  aes_round_sequencer_if.slave bus
);
  fsm_e       fsm_q, fsm_d;
  logic [3:0] rnd_q, rnd_d;
  aes_state_t st_q, st_d;
  aes_state_t round_out;
  logic       last_round;

  aes_round_sequencer_round u_round (
    .inState   (st_q),
    .roundKey  (bus.roundKey),
    .lastRound (last_round),
    .outState  (round_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      rnd_q <= '0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      st_q  <= st_d;
    end
  end

  always_comb begin
    fsm_d        = fsm_q;
    rnd_d        = rnd_q;
    st_d         = st_q;
    last_round   = 1'b0;
    bus.inReady  = 1'b0;
    bus.outValid = 1'b0;
    bus.keyIdx   = 4'd0;
    bus.busy     = 1'b1;
    case (fsm_q)
      IDLE: begin
        bus.inReady = 1'b1;
        bus.busy    = 1'b0;
        if (bus.inValid) begin
          st_d  = bus.inBlock ^ bus.roundKey;
          rnd_d = 4'd1;
          fsm_d = ROUND;
        end
      end
      ROUND: begin
        bus.keyIdx = rnd_q;
        st_d       = round_out;
        rnd_d      = rnd_q + 4'd1;
        if (rnd_q == 4'(NR - 1)) begin
          fsm_d = FINAL;
        end
      end
      FINAL: begin
        bus.keyIdx = 4'(NR);
        last_round = 1'b1;
        st_d       = round_out;
        fsm_d      = DONE;
      end
      DONE: begin
        bus.outValid = 1'b1;
        if (bus.outReady) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  assign bus.outBlock = st_q;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: FIPS-197 vector, key-index trace, backpressure, back-to-back, mid-run reset, random blocks.
module tb_aes_round_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_round_sequencer_if bus ();
  aes_round_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mc_col, mc_out;
  aes_round_sequencer_mix_column u_mc (.col(mc_col), .mixed(mc_out));

  logic [0:127] rk [0:15];
  assign bus.roundKey = rk[bus.keyIdx];

  int vectors;
  int miscompares;
  logic [7:0] sb [0:255];
  logic [3:0] ktrace [0:15];
  int nk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box derived from the field inverse and the affine map, independent of any table.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) begin
          inv = 8'(y);
          break;
        end
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_cipher(input logic [127:0] pt);
    logic [7:0] s [0:3][0:3];
    logic [7:0] t [0:3][0:3];
    logic [7:0] coef [0:3];
    logic [7:0] acc;
    logic [127:0] k, ct;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    k = rk[0];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = pt[127-8*(r+4*c) -: 8] ^ k[127-8*(r+4*c) -: 8];
    for (int n = 1; n <= 10; n++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb[s[r][(c+r)%4]];
      k = rk[n];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (n < 10) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc ^= gmul(coef[(j-r+4)%4], t[j][c]);
          end else begin
            acc = t[r][c];
          end
          s[r][c] = acc ^ k[127-8*(r+4*c) -: 8];
        end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ct[127-8*(r+4*c) -: 8] = s[r][c];
    return ct;
  endfunction

  // Presents pt for one cycle, then scrambles inBlock; returns cycles from accept cycle to outValid (-1 on timeout).
  task automatic encrypt(input logic [127:0] pt, output int lat);
    bit seen;
    int cyc;
    @(negedge clk);
    check("accept_ready", bus.inReady, 1'b1);
    bus.inValid = 1'b1;
    bus.inBlock = pt;
    for (int i = 0; i < 16; i++) ktrace[i] = 4'hf;
    ktrace[0] = bus.keyIdx;
    nk = 1;
    @(negedge clk);
    bus.inValid = 1'b0;
    bus.inBlock = {$urandom, $urandom, $urandom, $urandom};
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (nk < 16) begin
        ktrace[nk] = bus.keyIdx;
        nk++;
      end
      if (bus.outValid) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    lat = seen ? cyc : -1;
  endtask

  initial begin
    logic [127:0] pt, key, c1_ct, p1, p2;
    logic [47:0] tr_obs, tr_exp;
    logic [127:0] outs [0:1];
    int acc [0:1];
    int lat, na, no;
    bit found, saw;

    vectors = 0;
    miscompares = 0;
    bus.inValid = 1'b0;
    bus.inBlock = '0;
    bus.outReady = 1'b0;
    for (int r = 0; r < 16; r++) rk[r] = '0;
    build_sbox();
    mc_col = 32'hdb135345;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_outValid", bus.outValid, 1'b0);
    check("rst_keyIdx", bus.keyIdx, 4'd0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_inReady", bus.inReady, 1'b1);
    check("rst_outBlock", bus.outBlock, 128'h0);
    check("mixcol_db135345", mc_out, 32'h8e4da1bc);

    // FIPS-197 C.1 with the consumer stalled, then a 20-cycle backpressure window
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    pt = 128'h00112233445566778899aabbccddeeff;
    c1_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    encrypt(pt, lat);
    check("c1_latency", lat, 11);
    check("c1_outBlock", bus.outBlock, c1_ct);
    check("c1_model", bus.outBlock, ref_cipher(pt));
    for (int i = 0; i < 12; i++) begin
      tr_obs[47-4*i -: 4] = ktrace[i];
      tr_exp[47-4*i -: 4] = (i <= 10) ? 4'(i) : 4'd0;
    end
    check("keyidx_trace", tr_obs, tr_exp);
    for (int i = 0; i < 20; i++) begin
      bus.inValid = i[0];
      bus.inBlock = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("bp_hold", {bus.outValid, bus.inReady, bus.outBlock}, {2'b10, c1_ct});
    end
    bus.inValid = 1'b0;
    bus.outReady = 1'b1;
    @(negedge clk);
    check("bp_release", {bus.outValid, bus.busy, bus.inReady}, 3'b001);

    // Random keys and plaintexts, alternating immediate and delayed consumer
    for (int n = 0; n < 6; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      bus.outReady = n[0];
      encrypt(pt, lat);
      check("rand_lat", lat, 11);
      check("rand_ct", bus.outBlock, ref_cipher(pt));
      if (!bus.outReady) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          check("rand_hold", {bus.outValid, bus.outBlock}, {1'b1, ref_cipher(pt)});
        end
        bus.outReady = 1'b1;
      end
      @(negedge clk);
      check("rand_idle", {bus.busy, bus.outValid}, 2'b00);
    end

    // Back-to-back with inValid held high
    key = {$urandom, $urandom, $urandom, $urandom};
    load_key(key);
    p1 = {$urandom, $urandom, $urandom, $urandom};
    p2 = {$urandom, $urandom, $urandom, $urandom};
    bus.outReady = 1'b1;
    acc[0] = 0; acc[1] = 0;
    outs[0] = '0; outs[1] = '0;
    na = 0; no = 0;
    @(negedge clk);
    bus.inValid = 1'b1;
    bus.inBlock = p1;
    for (int cyc = 0; cyc < 60 && no < 2; cyc++) begin
      if (bus.outValid && no < 2) begin
        outs[no] = bus.outBlock;
        no++;
      end
      if (bus.inValid && bus.inReady && na < 2) begin
        acc[na] = cyc;
        na++;
      end
      @(negedge clk);
      if (na == 1) bus.inBlock = p2;
      if (na == 2) bus.inValid = 1'b0;
    end
    bus.inValid = 1'b0;
    check("b2b_accepts", na, 2);
    check("b2b_gap", acc[1] - acc[0], 12);
    check("b2b_ct1", outs[0], ref_cipher(p1));
    check("b2b_ct2", outs[1], ref_cipher(p2));

    // Reset during round 5
    @(negedge clk);
    pt = {$urandom, $urandom, $urandom, $urandom};
    check("mid_ready", bus.inReady, 1'b1);
    bus.inValid = 1'b1;
    bus.inBlock = pt;
    @(negedge clk);
    bus.inValid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.keyIdx == 4'd5) found = 1'b1;
      else @(negedge clk);
    end
    check("mid_reach_r5", found, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_state", {bus.busy, bus.inReady, bus.outValid, bus.outBlock}, {3'b010, 128'h0});
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw |= bus.outValid;
    end
    check("mid_no_outValid", saw, 1'b0);

    // Recovery after the aborted block
    pt = {$urandom, $urandom, $urandom, $urandom};
    encrypt(pt, lat);
    check("post_rst_lat", lat, 11);
    check("post_rst_ct", bus.outBlock, ref_cipher(pt));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Iterative AES-128 encryption controller that owns one combinational round datapath (SubBytes, ShiftRows, mixColumns, AddRoundKey) and sequences it over the 10 cipher rounds, one round per clock. It sits between the block-input interface and the ciphertext consumer. It fetches round keys by index from the key-expansion store and bypasses mixColumns in round 10. Byte order follows the codebase state convention: bit 0 is the MSB of byte 0, and bytes are column-major.

## Interface
- No parameters; AES-128 only, with NR = 10 rounds fixed in the package.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- inValid  input  1  plaintext offered.
- inReady  output  1  sequencer can accept plaintext.
- inBlock  input  [0:127]  plaintext.
- keyIdx  output  [3:0]  round-key index requested from the key store.
- roundKey  input  [0:127]  key for keyIdx, combinational, valid in the same cycle.
- outValid  output  1  ciphertext available.
- outReady  input  1  consumer takes ciphertext.
- outBlock  output  [0:127]  ciphertext; the state register drives it directly.
- busy  output  1  high in every state other than IDLE.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE. The 4-bit round counter `rnd` holds 1..10.
- IDLE
  - inReady=1, keyIdx=0.
  - On inValid&&inReady: state ← inBlock ^ roundKey (key 0), rnd ← 1, go to ROUND.
- ROUND
  - keyIdx=rnd.
  - state ← AddRoundKey(mixColumns(ShiftRows(SubBytes(state))), roundKey), rnd ← rnd+1.
  - Go to FINAL when rnd==9 at the edge, otherwise stay in ROUND.
- FINAL
  - keyIdx=10.
  - state ← AddRoundKey(ShiftRows(SubBytes(state)), roundKey), with mixColumns bypassed.
  - Go to DONE.
- DONE
  - outValid=1; outBlock holds steady; keyIdx=0.
  - On outReady: go to IDLE.
  - Without outReady: stay in DONE indefinitely with outBlock stable.
- inReady is 1 only in IDLE. In every other state inValid is ignored and inBlock may change freely.
- outValid is 1 only in DONE. Output transfer completes on outValid&&outReady.
- No pipelining: at most one block in flight.
- All arithmetic is GF(2^8) byte-wise.
  - The state register is 128 bits.
  - rnd is a 4-bit counter and never exceeds 10.
  - Illegal FSM encodings return to IDLE.

## Timing
- Reset values: state register 0, rnd 0, FSM IDLE.
  - Outputs after reset: inReady=1, outValid=0, busy=0, keyIdx=0, outBlock=0.
- Accept edge is T. Rounds 1..9 execute at edges T+1..T+9, and round 10 at edge T+10.
- outValid rises in the cycle after edge T+10. Latency is 11 clocks from accept to outValid.
- If outReady is already high, DONE lasts exactly 1 cycle. IDLE follows, and the earliest next accept is 2 cycles after outValid first rose.
- Throughput: one block per 12 clocks at best.
- keyIdx is a Moore output (depends only on FSM state and rnd), so the key store sees a stable index for the whole cycle.
- If reset is asserted mid-operation, the next edge forces IDLE with all registers at their reset values. The partial result is discarded and no outValid pulse is produced.
- A simultaneous inValid during DONE with outReady: the output transfers and the input is not accepted in that cycle.

## Structure
- Shared package `aesPkg` contains:
  - NR=10;
  - state type `logic [0:127]`;
  - FSM state enum;
  - the S-box constant table;
  - functions mulBy2 and mulBy3.
- Natural sub-module: `aesRound`, a combinational round with ports inState, roundKey, lastRound, outState.
  - It instantiates the existing mixColumns.
  - lastRound selects the bypass path.
- The sequencer itself holds only the FSM, rnd, the state register and the handshake logic.

## Test plan
- FIPS-197 C.1 vector:
  - key store loaded from key 000102030405060708090a0b0c0d0e0f;
  - inBlock=00112233445566778899aabbccddeeff;
  - required: outBlock=69c4e0d86a7b0430d8cdb78070b4c55a, with outValid exactly 11 clocks after the accept edge.
- keyIdx trace: sample keyIdx over one encryption → must read 0,1,2,…,10,0. Checks that the round-1 column bytes db,13,53,45 → 8e,4d,a1,bc.
- Backpressure: hold outReady=0 for 20 cycles after completion → outValid stays 1 and outBlock is stable; inValid pulses in this window are not accepted (inReady=0).
- Back-to-back: two blocks with inValid held high and outReady=1 → second accept occurs 12 clocks after the first, and both ciphertexts match the reference model.
- Reset mid-operation: rst_n=0 for 1 cycle at round 5 → next cycle shows busy=0, inReady=1, outBlock=0; no outValid pulse.
- Reset values: after reset with no stimulus → outValid=0, keyIdx=0, busy=0.
